// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, PC+4 adder, next-PC select and
// instruction ROM (constant table where word i = 32'h2000_0000 + i).
module if_stage #(
  parameter int unsigned IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  output logic [31:0] PC,
  output logic [31:0] pc4,
  output logic [31:0] inst
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IMEM_DEPTH = 1 << IMEM_AW;
  localparam logic [XLEN-1:0] ROM_BASE = 32'h2000_0000;

  logic [XLEN-1:0]    next_pc;
  logic [IMEM_AW-1:0] word_idx;

  // Sequential address; wraps naturally modulo 2^32
  assign pc4 = PC + XLEN'(4);

  // Next-PC select: bit 1 chooses the jump target, whatever bit 0 is
  always_comb begin
    next_pc = pc4;
    if (pcsource[1]) begin
      next_pc = jpc;
    end else if (pcsource[0]) begin
      next_pc = bpc;
    end
  end

  // Program counter; targets load unmodified, no enable
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      PC <= RESET_PC;
    end else begin
      PC <= next_pc;
    end
  end

  // Byte-offset and upper address bits are dropped, so addresses alias
  assign word_idx = PC[IMEM_AW+1:2];

  logic [XLEN-1:0] rom [IMEM_DEPTH];

  // Constant ROM table: each word holds its own index offset from the base
  always_comb begin
    for (int unsigned i = 0; i < IMEM_DEPTH; i++) begin
      rom[i] = ROM_BASE + XLEN'(i);
    end
  end

  // Asynchronous ROM read
  always_comb begin
    inst = rom[word_idx];
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for the instruction-fetch stage.
module tb_if_stage;

  logic        clk;
  logic        clrn;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] PC;
  logic [31:0] pc4;
  logic [31:0] inst;

  int checks;
  int errors;

  if_stage dut (
    .clk      (clk),
    .clrn     (clrn),
    .pcsource (pcsource),
    .bpc      (bpc),
    .jpc      (jpc),
    .PC       (PC),
    .pc4      (pc4),
    .inst     (inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn     = 1'b0;
    pcsource = 2'b01;
    bpc      = 32'h32;
    jpc      = 32'h0;
    #2;
    for (int e = 0; e < 2; e++) begin
      step();
      checks++;
      if (PC !== 32'h0) begin
        errors++;
        $display("FAIL reset_pc edge%0d got %h exp %h", e, PC, 32'h0);
      end
      checks++;
      if (pc4 !== 32'h4) begin
        errors++;
        $display("FAIL reset_pc4 edge%0d got %h exp %h", e, pc4, 32'h4);
      end
      checks++;
      if (inst !== 32'h2000_0000) begin
        errors++;
        $display("FAIL reset_inst edge%0d got %h exp %h", e, inst, 32'h2000_0000);
      end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc  [3];
    logic [31:0] exp_ins [3];
    exp_pc  = '{32'h4, 32'h8, 32'hC};
    exp_ins = '{32'h2000_0001, 32'h2000_0002, 32'h2000_0003};
    @(negedge clk);
    clrn     = 1'b1;
    pcsource = 2'b00;
    for (int e = 0; e < 3; e++) begin
      step();
      checks++;
      if (PC !== exp_pc[e]) begin
        errors++;
        $display("FAIL seq_pc step%0d got %h exp %h", e, PC, exp_pc[e]);
      end
      checks++;
      if (inst !== exp_ins[e]) begin
        errors++;
        $display("FAIL seq_inst step%0d got %h exp %h", e, inst, exp_ins[e]);
      end
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    pcsource = 2'b01;
    bpc      = 32'h32;
    step();
    checks++;
    if (PC !== 32'h32) begin
      errors++;
      $display("FAIL branch_pc got %h exp %h", PC, 32'h32);
    end
    checks++;
    if (pc4 !== 32'h36) begin
      errors++;
      $display("FAIL branch_pc4 got %h exp %h", pc4, 32'h36);
    end
    checks++;
    if (inst !== 32'h2000_000C) begin
      errors++;
      $display("FAIL branch_inst got %h exp %h", inst, 32'h2000_000C);
    end
  endtask

  // Inputs changed between edges must not disturb PC
  task automatic test_sample_at_edge();
    #1;
    pcsource = 2'b10;
    jpc      = 32'h100;
    #1;
    checks++;
    if (PC !== 32'h32) begin
      errors++;
      $display("FAIL midcycle_hold_pc got %h exp %h", PC, 32'h32);
    end
  endtask

  task automatic test_jump();
    logic [1:0] sel [2];
    sel = '{2'b10, 2'b11};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      pcsource = sel[k];
      jpc      = 32'h54;
      bpc      = 32'h999;
      step();
      checks++;
      if (PC !== 32'h54) begin
        errors++;
        $display("FAIL jump_pc sel%b got %h exp %h", sel[k], PC, 32'h54);
      end
      checks++;
      if (pc4 !== 32'h58) begin
        errors++;
        $display("FAIL jump_pc4 sel%b got %h exp %h", sel[k], pc4, 32'h58);
      end
      checks++;
      if (inst !== 32'h2000_0015) begin
        errors++;
        $display("FAIL jump_inst sel%b got %h exp %h", sel[k], inst, 32'h2000_0015);
      end
    end
  endtask

  task automatic test_wrap_alias();
    @(negedge clk);
    pcsource = 2'b01;
    bpc      = 32'hFFFF_FFFC;
    step();
    checks++;
    if (PC !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_pc got %h exp %h", PC, 32'hFFFF_FFFC);
    end
    checks++;
    if (pc4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc4 got %h exp %h", pc4, 32'h0);
    end
    checks++;
    if (inst !== 32'h2000_003F) begin
      errors++;
      $display("FAIL wrap_inst got %h exp %h", inst, 32'h2000_003F);
    end
    @(negedge clk);
    pcsource = 2'b00;
    step();
    checks++;
    if (PC !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next_pc got %h exp %h", PC, 32'h0);
    end
  endtask

  // Unaligned target loads as-is; low bits ignored for the ROM index
  task automatic test_unaligned();
    @(negedge clk);
    pcsource = 2'b01;
    bpc      = 32'h0000_0107;
    step();
    checks++;
    if (PC !== 32'h0000_0107) begin
      errors++;
      $display("FAIL unaligned_pc got %h exp %h", PC, 32'h0000_0107);
    end
    checks++;
    if (inst !== 32'h2000_0001) begin
      errors++;
      $display("FAIL unaligned_inst got %h exp %h", inst, 32'h2000_0001);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pcsource = 2'b10;
    jpc      = 32'h54;
    step();
    checks++;
    if (PC !== 32'h54) begin
      errors++;
      $display("FAIL async_setup_pc got %h exp %h", PC, 32'h54);
    end
    pcsource = 2'b01;
    bpc      = 32'h200;
    #2;
    clrn = 1'b0;
    #1;
    checks++;
    if (PC !== 32'h0) begin
      errors++;
      $display("FAIL async_pc got %h exp %h", PC, 32'h0);
    end
    checks++;
    if (pc4 !== 32'h4) begin
      errors++;
      $display("FAIL async_pc4 got %h exp %h", pc4, 32'h4);
    end
    checks++;
    if (inst !== 32'h2000_0000) begin
      errors++;
      $display("FAIL async_inst got %h exp %h", inst, 32'h2000_0000);
    end
    step();
    checks++;
    if (PC !== 32'h0) begin
      errors++;
      $display("FAIL async_held_pc got %h exp %h", PC, 32'h0);
    end
    @(negedge clk);
    clrn     = 1'b1;
    pcsource = 2'b00;
    step();
    checks++;
    if (PC !== 32'h4) begin
      errors++;
      $display("FAIL async_release_pc got %h exp %h", PC, 32'h4);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_sample_at_edge();
    test_jump();
    test_wrap_alias();
    test_unaligned();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
